// File: rtl/mem_responder.sv
// Word-organised unified instruction/data memory answering fetch/load/store requests
// through a MemReq/MemReady handshake with a fixed number of wait states.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MisalignErr,
  output logic        Busy
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WaitLoad = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, wd_q;
  logic        we_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem [Depth];

  logic        accept;
  logic        enter_resp;
  logic [31:0] acc_adr, acc_wd;
  logic        acc_we;
  logic        acc_mis;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic        mem_we;
  logic        unused_adr;

  // With zero wait states RESP is entered from IDLE, so the live inputs are the access.
  always_comb begin
    acc_adr = adr_q;
    acc_we  = we_q;
    acc_wd  = wd_q;
    if (state_q == StIdle) begin
      acc_adr = Adr;
      acc_we  = MemWrite;
      acc_wd  = WriteData;
    end
  end

  assign acc_idx    = acc_adr[ADDR_WIDTH+1:2];
  assign acc_mis    = |acc_adr[1:0];
  assign unused_adr = ^acc_adr[31:ADDR_WIDTH+2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MemReq) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end else begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A misaligned store is suppressed and returns the untouched word.
  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp) begin
      if (acc_we && !acc_mis) rdata_d = acc_wd;
      else                    rdata_d = mem[acc_idx];
    end
  end

  assign mem_we = enter_resp && acc_we && !acc_mis && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      adr_q   <= 32'd0;
      wd_q    <= 32'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (accept) begin
        adr_q <= Adr;
        wd_q  <= WriteData;
        we_q  <= MemWrite;
      end
    end
  end

  // Storage is deliberately outside reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= acc_wd;
  end

  assign ReadData    = rdata_q;
  assign MemReady    = (state_q == StResp);
  assign MisalignErr = (state_q == StResp) && (|adr_q[1:0]);
  assign Busy        = (state_q == StWait);

endmodule

// File: tb/tb_mem_responder.sv
// Randomised and directed checks of mem_responder against a word-array model,
// using one instance with two wait states and one with none.
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_a, we_a, req_b, we_b;
  logic [31:0] adr_a, wd_a, adr_b, wd_b;
  logic [31:0] rd_a, rd_b;
  logic        rdy_a, rdy_b, mis_a, mis_b, busy_a, busy_b;

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .MemReq(req_a), .MemWrite(we_a), .Adr(adr_a),
    .WriteData(wd_a), .ReadData(rd_a), .MemReady(rdy_a), .MisalignErr(mis_a), .Busy(busy_a)
  );

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .MemReq(req_b), .MemWrite(we_b), .Adr(adr_b),
    .WriteData(wd_b), .ReadData(rd_b), .MemReady(rdy_b), .MisalignErr(mis_b), .Busy(busy_b)
  );

  bit          cur_sel;
  logic [31:0] rd_o;
  logic        rdy_o, mis_o, busy_o;
  assign rd_o   = cur_sel ? rd_b : rd_a;
  assign rdy_o  = cur_sel ? rdy_b : rdy_a;
  assign mis_o  = cur_sel ? mis_b : mis_a;
  assign busy_o = cur_sel ? busy_b : busy_a;

  logic [31:0] model [2][256];
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit rq, input bit we, input logic [31:0] a,
                       input logic [31:0] wd);
    if (sel) begin
      req_b = rq; we_b = we; adr_b = a; wd_b = wd;
    end else begin
      req_a = rq; we_a = we; adr_a = a; wd_a = wd;
    end
  endtask

  // One complete access; inputs are scrambled while it is in flight.
  task automatic acc(input bit sel, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input string tag);
    int n;
    int bc;
    logic [31:0] exp;
    logic [7:0] idx;
    bit mis;
    cur_sel = sel;
    @(negedge clk);
    drive(sel, 1'b1, we, a, wd);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, 1'b1, a + 32'd4, $urandom);
    n  = 1;
    bc = busy_o ? 1 : 0;
    while (!rdy_o && n < 16) begin
      @(negedge clk);
      n++;
      if (busy_o) bc++;
    end
    idx = a[9:2];
    mis = (a[1:0] != 2'b00);
    exp = (we && !mis) ? wd : model[sel][idx];
    if (we && !mis) model[sel][idx] = wd;
    check({tag, ".latency"}, 32'(n), sel ? 32'd1 : 32'd3);
    check({tag, ".busy_cycles"}, 32'(bc), sel ? 32'd0 : 32'd2);
    check({tag, ".rdata"}, rd_o, exp);
    check({tag, ".misalign"}, {31'd0, mis_o}, {31'd0, mis});
  endtask

  initial begin
    int cnt;
    logic [31:0] a;
    int idx;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset.rdata", rd_a, 32'd0);
    check("reset.ready", {31'd0, rdy_a}, 32'd0);
    check("reset.misalign", {31'd0, mis_a}, 32'd0);
    check("reset.busy", {31'd0, busy_a}, 32'd0);

    for (int i = 0; i < 18; i++) acc(1'b0, 1'b1, 32'(i * 4), $urandom, "preload");
    acc(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, "wr10");
    acc(1'b0, 1'b0, 32'h10, 32'd0, "rd10");

    for (int i = 0; i < 3; i++) acc(1'b1, 1'b1, 32'(i * 4), 32'(i + 1), "b_preload");
    cur_sel = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("stream.ready", {31'd0, rdy_b}, 32'd1);
      check("stream.rdata", rd_b, 32'(k + 1));
      adr_b = 32'((k + 1) * 4);
      if (k == 2) req_b = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("stream.gap", {31'd0, rdy_b}, 32'd0);
    end

    acc(1'b0, 1'b1, 32'h20, 32'hAAAA_0000, "wr20");
    acc(1'b0, 1'b1, 32'h21, 32'h1234_5678, "mis_wr21");
    acc(1'b0, 1'b0, 32'h20, 32'd0, "rd20");
    acc(1'b0, 1'b1, 32'h400, 32'h55, "wr400");
    acc(1'b0, 1'b0, 32'h000, 32'd0, "rd000");

    acc(1'b0, 1'b1, 32'h30, 32'd0, "wr30");
    cur_sel = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'hCAFE_F00D);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_wait.rdata", rd_a, 32'd0);
    check("rst_wait.busy", {31'd0, busy_a}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (rdy_a) cnt++;
      @(negedge clk);
    end
    check("rst_wait.no_ready", 32'(cnt), 32'd0);
    acc(1'b0, 1'b0, 32'h30, 32'd0, "rd30");

    acc(1'b0, 1'b1, 32'h40, 32'h77, "wr40");
    acc(1'b0, 1'b0, 32'h40, 32'd0, "rd40");
    acc(1'b0, 1'b0, 32'h44, 32'd0, "rd44");

    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 17);
      a = ($urandom & 32'hFFFF_FC00) | 32'(idx << 2);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      acc(1'(i % 4 == 3), 1'($urandom_range(0, 1)), a, $urandom, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Unified instruction/data memory for the multicycle MIPS core.
- Sits on the datapath's memory port, opposite the controller-driven requester. It answers fetch, load and store requests through a request/ready handshake with a configurable number of wait states.
- The requester holds its state machine in the memory state until MemReady pulses.
- Data width is fixed at 32 bits. Storage is word-organised.

Parameters:
- ADDR_WIDTH, 8, number of word-index bits; depth is 2**ADDR_WIDTH words.
- WAIT_CYCLES, 2, wait states inserted before the response; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- MemReq  input  1  access request, sampled in IDLE only
- MemWrite  input  1  1 = store, 0 = read; captured with MemReq
- Adr  input  32  byte address; word index is Adr[ADDR_WIDTH+1:2]
- WriteData  input  32  store data; captured with MemReq
- ReadData  output  32  registered read data
- MemReady  output  1  one-cycle response pulse
- MisalignErr  output  1  pulses with MemReady when the captured Adr[1:0] != 0
- Busy  output  1  high while a request is accepted but not yet answered

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; wait counter, ReadData, MemReady, MisalignErr and Busy all go to 0.
  - Memory array contents are not cleared and are unaffected by reset.
- State machine has three states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with MemReq=1, capture Adr, MemWrite and WriteData into holding registers and set Busy=1.
  - Next state is WAIT if WAIT_CYCLES>0 (counter loads WAIT_CYCLES-1), else RESP.
- WAIT:
  - Counter decrements each edge; go to RESP on the edge where the counter is 0.
  - Busy=1. Requester inputs are ignored; only the captured copies are used.
- RESP (exactly one cycle): MemReady=1, Busy=0, then unconditionally back to IDLE.
  - MemReq is ignored while in RESP.
- Latency:
  - MemReady is high in the (WAIT_CYCLES+1)th cycle after the accepting edge.
  - Minimum spacing between accepts is WAIT_CYCLES+2 cycles.
  - A requester that keeps MemReq high through RESP starts a new access in the following IDLE cycle. Back-to-back requests are legal.
- Memory commit happens on the edge that enters RESP:
  - Store: mem[idx] <= captured WriteData; ReadData <= captured WriteData.
  - Read: ReadData <= mem[idx].
- ReadData holds its value until the next RESP entry or reset.
- Misalignment: captured Adr[1:0] != 0 gives MisalignErr=1 during RESP.
  - A store is suppressed; memory is unchanged and ReadData <= old mem[idx].
  - A read returns the aligned word.
- Address wrap: Adr bits above ADDR_WIDTH+1 are ignored, so an address aliases to idx modulo 2**ADDR_WIDTH.
- Ordering: a read issued after a store to the same word returns the stored value (accesses are strictly sequential).
- Reset mid-operation (in WAIT, or on the RESP-entry edge): the pending access is aborted, no write is performed, and no MemReady is produced.
- Reset has priority over any MemReq on the same edge.
- MemWrite or WriteData changes during WAIT have no effect.

Test Plan:
1. Write then read, WAIT_CYCLES=2.
   - Stimulus: store 0xDEADBEEF to Adr 0x10, then read Adr 0x10.
   - Required: MemReady exactly 3 cycles after each accept; read gives ReadData=0xDEADBEEF; Busy high for 2 cycles per access.
2. Zero wait states, WAIT_CYCLES=0.
   - Stimulus: hold MemReq=1 continuously with reads of 0x00, 0x04, 0x08 preloaded with 1, 2, 3.
   - Required: MemReady every 2nd cycle with ReadData 1, 2, 3 in order.
3. Misaligned store.
   - Stimulus: store 0x12345678 to Adr 0x21 (word 8 holds 0xAAAA0000).
   - Required: MisalignErr=1 with MemReady; word 8 still reads 0xAAAA0000.
4. Address wrap, ADDR_WIDTH=8.
   - Stimulus: store 0x55 to Adr 0x400, then read Adr 0x000.
   - Required: read returns 0x55.
5. Reset mid-WAIT.
   - Stimulus: start a store of 0xCAFEF00D to Adr 0x30 (old value 0x0); assert reset one cycle later.
   - Required: no MemReady; ReadData=0, Busy=0; a later read of 0x30 returns 0x0.
6. Input change during WAIT.
   - Stimulus: accept a read of 0x40 (holds 0x77), then change Adr to 0x44 and MemWrite to 1 during WAIT.
   - Required: ReadData=0x77 and memory unchanged.
